// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register word feeder.
// Direction codes and FSM state encoding.
package shift_pkg;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/shift_word_feeder.sv
// Serialises parallel words onto a bidirectional shift register's
// d/en/dir inputs, accepting them on a valid/ready handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready word handshake (accept = valid & ready)
//   in_word, in_dir   word to serialise and its shift direction
//   pause             stalls shifting while high
//   d, en, dir        serial data, shift enable, direction
//   busy              a word is being serialised
//   done              pulse alongside the last bit's enable
module shift_word_feeder
   import shift_pkg::*;
#(
   parameter int MSB = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [MSB-1:0] in_word,
   input  logic           in_dir,
   input  logic           pause,
   output logic           d,
   output logic           en,
   output logic           dir,
   output logic           busy,
   output logic           done
);

   localparam int CW = $clog2(MSB);
   localparam logic [CW-1:0] LAST = CW'(MSB - 1);

   state_t         state, state_n;
   logic [CW-1:0]  cnt, cnt_n, nxt;
   logic [MSB-1:0] shadow, shadow_n;
   logic           d_n, dir_n;
   logic           last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         shadow <= '0;
         d      <= 1'b0;
         dir    <= DIR_LEFT;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         shadow <= shadow_n;
         d      <= d_n;
         dir    <= dir_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      shadow_n = shadow;
      d_n      = d;
      dir_n    = dir;
      en       = 1'b0;
      done     = 1'b0;
      in_ready = 1'b0;
      busy     = 1'b0;
      last     = (cnt == LAST);
      nxt      = cnt + CW'(1);

      unique case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
         end
         ST_SHIFT: begin
            busy     = 1'b1;
            en       = ~pause;
            done     = en & last;
            in_ready = last & ~pause;
            // d is registered, so preload the next bit as this one shifts
            if (en && !last) begin
               cnt_n = nxt;
               d_n   = (dir == DIR_RIGHT) ? shadow[nxt]
                                          : shadow[LAST - nxt];
            end else if (en) begin
               state_n = ST_IDLE;
            end
         end
         default: ;
      endcase

      // Accept overrides the end-of-word return to IDLE, giving
      // back-to-back words without a bubble.
      if (in_valid && in_ready) begin
         state_n  = ST_SHIFT;
         cnt_n    = '0;
         shadow_n = in_word;
         dir_n    = in_dir;
         d_n      = (in_dir == DIR_RIGHT) ? in_word[0]
                                          : in_word[MSB-1];
      end
   end

endmodule

// File: tb/tb_shift_word_feeder.sv
// Self-checking bench for shift_word_feeder driving a modelled
// bidirectional shift register.
module tb_shift_word_feeder;
   import shift_pkg::*;

   localparam int MSB = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [MSB-1:0] in_word;
   logic           in_dir;
   logic           pause;
   logic           d, en, dir, busy, done;
   logic [MSB-1:0] out = '0;

   always #10 clk = ~clk;

   shift_word_feeder #(.MSB(MSB)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_word  (in_word),
      .in_dir   (in_dir),
      .pause    (pause),
      .d        (d),
      .en       (en),
      .dir      (dir),
      .busy     (busy),
      .done     (done)
   );

   // downstream bidirectional shift register
   always @(posedge clk)
      if (en)
         out <= (dir == DIR_RIGHT) ? {d, out[MSB-1:1]}
                                   : {out[MSB-2:0], d};

   typedef struct {
      logic d;
      logic dir;
      logic last;
   } bit_t;

   typedef struct {
      logic [MSB-1:0] word;
      logic           dr;
   } vec_t;

   bit_t q[$];
   bit_t me;
   int   nvec = 0;
   int   nerr = 0;
   int   en_cnt = 0;
   int   busy_cnt = 0;

   task automatic check(string name, logic [31:0] act,
                        logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: pop on each enabled bit, push on each accept
   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (en) begin
         en_cnt++;
         if (q.size() == 0) begin
            check("en_unexpected", 32'(en), 32'(0));
         end else begin
            me = q.pop_front();
            check("d", 32'(d), 32'(me.d));
            check("dir", 32'(dir), 32'(me.dir));
            check("done", 32'(done), 32'(me.last));
         end
      end else begin
         check("done_no_en", 32'(done), 32'(0));
      end
      if (rst) begin
         q.delete();
      end else if (in_valid && in_ready) begin
         for (int i = 0; i < MSB; i++) begin
            me.d    = in_dir ? in_word[i] : in_word[MSB-1-i];
            me.dir  = in_dir;
            me.last = (i == MSB - 1);
            q.push_back(me);
         end
      end
   end

   // caller sits just after a posedge; returns just after accept edge
   task automatic send(logic [MSB-1:0] w, logic dr, logic hold);
      logic ok;
      in_word  = w;
      in_dir   = dr;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("accept_timeout", 32'(ok), 32'(1));
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic drain();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy && q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain_timeout", 32'(ok), 32'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_bits(int base, int n);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         if (en_cnt - base >= n) begin
            ok = 1'b1;
            break;
         end
      end
      check("bit_timeout", 32'(ok), 32'(1));
      #1;
   endtask

   vec_t vt[6];
   int   e0, b0;

   initial begin
      vt[0] = '{4'b1011, DIR_LEFT};
      vt[1] = '{4'b1011, DIR_RIGHT};
      vt[2] = '{4'b0001, DIR_LEFT};
      vt[3] = '{4'b1000, DIR_RIGHT};
      vt[4] = '{4'b1110, DIR_LEFT};
      vt[5] = '{4'b0111, DIR_RIGHT};

      rst = 1'b1;
      in_valid = 1'b0;
      in_word = '0;
      in_dir = 1'b0;
      pause = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_en", 32'(en), 32'(0));
      check("rst_d", 32'(d), 32'(0));
      check("rst_dir", 32'(dir), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(in_ready), 32'(1));
      @(posedge clk);
      #1;

      // single words, both directions
      foreach (vt[k]) begin
         e0 = en_cnt;
         send(vt[k].word, vt[k].dr, 1'b0);
         drain();
         check("vec_out", 32'(out), 32'(vt[k].word));
         check("vec_bits", 32'(en_cnt - e0), 32'(MSB));
      end

      // back-to-back words with valid held
      e0 = en_cnt;
      b0 = busy_cnt;
      send(4'b1100, DIR_LEFT, 1'b1);
      send(4'b0011, DIR_RIGHT, 1'b0);
      drain();
      check("b2b_out", 32'(out), 32'(4'b0011));
      check("b2b_bits", 32'(en_cnt - e0), 32'(8));
      check("b2b_busy", 32'(busy_cnt - b0), 32'(8));

      // pause after bit 2
      e0 = en_cnt;
      b0 = busy_cnt;
      send(4'b0110, DIR_LEFT, 1'b0);
      wait_bits(e0, 2);
      pause = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("pause_en", 32'(en), 32'(0));
         check("pause_d", 32'(d), 32'(1));
         check("pause_busy", 32'(busy), 32'(1));
         @(posedge clk);
      end
      #1 pause = 1'b0;
      drain();
      check("pause_out", 32'(out), 32'(4'b0110));
      check("pause_bits", 32'(en_cnt - e0), 32'(4));
      check("pause_busy_len", 32'(busy_cnt - b0), 32'(7));

      // pause in IDLE does not block accept
      pause = 1'b1;
      @(negedge clk);
      check("idle_pause_ready", 32'(in_ready), 32'(1));
      @(posedge clk);
      #1 pause = 1'b0;

      // reset during bit 2
      e0 = en_cnt;
      send(4'b1111, DIR_LEFT, 1'b0);
      wait_bits(e0, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_en", 32'(en), 32'(0));
      check("mid_rst_busy", 32'(busy), 32'(0));
      check("mid_rst_ready", 32'(in_ready), 32'(1));
      check("mid_rst_d", 32'(d), 32'(0));
      @(posedge clk);
      #1;
      send(4'b0101, DIR_LEFT, 1'b0);
      drain();
      check("post_rst_out", 32'(out), 32'(4'b0101));

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
